// File: rtl/pattern_pkg.sv
// Shared definitions for the test-pattern configuration controller.
// Pattern codes, auto-cycle bounds and controller state encoding.
package pattern_pkg;

  localparam logic [7:0] PAT_NONE   = 8'd0;
  localparam logic [7:0] PAT_BORDER = 8'd1;
  localparam logic [7:0] PAT_MOIREX = 8'd2;
  localparam logic [7:0] PAT_MOIREY = 8'd3;
  localparam logic [7:0] PAT_RAMP   = 8'd4;

  localparam logic [7:0] PAT_FIRST_AUTO = PAT_BORDER;
  localparam logic [7:0] PAT_LAST_AUTO  = PAT_RAMP;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_ARM  = 2'd2
  } state_e;

  // Next pattern in the auto-cycle ring; out-of-ring codes restart at the first.
  function automatic logic [7:0] next_auto(input logic [7:0] p);
    if (p >= PAT_FIRST_AUTO && p < PAT_LAST_AUTO) begin
      return p + 8'd1;
    end
    return PAT_FIRST_AUTO;
  endfunction

endpackage

// File: rtl/ramp_step_div.sv
// Serial restoring divider: step = floor(2^(B+F) / divisor).
// One quotient bit per cycle MSB first; saturates and flags divide-by-zero.
module ramp_step_div #(
  parameter int B               = 8,
  parameter int X_BITS          = 13,
  parameter int FRACTIONAL_BITS = 12
) (
  input  logic                          clk_in,
  input  logic                          reset,
  input  logic                          start,
  input  logic [X_BITS-1:0]             divisor,
  output logic                          done,
  output logic [B+FRACTIONAL_BITS-1:0]  step,
  output logic                          err
);

  localparam int SW = B + FRACTIONAL_BITS;
  localparam int N  = SW + 1;
  localparam int CW = $clog2(N + 1);

  logic [X_BITS-1:0] div_q, div_d;
  logic [X_BITS-1:0] rem_q, rem_d;
  logic [N-2:0]      quo_q, quo_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [SW-1:0]     step_q, step_d;

  logic              num_bit;
  logic [X_BITS:0]   trial;
  logic              ge;
  logic [N-1:0]      quo_next;

  // One restoring iteration per cycle; the numerator is a lone leading one.
  always_comb begin
    div_d    = div_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    step_d   = step_q;
    num_bit  = (cnt_q == CW'(N));
    trial    = {rem_q, num_bit};
    ge       = (trial >= {1'b0, div_q});
    quo_next = {quo_q, ge};
    if (start) begin
      div_d  = divisor;
      rem_d  = '0;
      quo_d  = '0;
      cnt_d  = CW'(N);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = X_BITS'(ge ? trial - {1'b0, div_q} : trial);
      quo_d = quo_next[N-2:0];
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        err_d  = (div_q == '0);
        if (div_q == '0) begin
          step_d = '0;
        end else if (quo_next[N-1]) begin
          step_d = '1;
        end else begin
          step_d = quo_next[SW-1:0];
        end
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      step_q <= '0;
    end else begin
      div_q  <= div_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
      step_q <= step_d;
    end
  end

  assign done = done_q;
  assign step = step_q;
  assign err  = err_q;

endmodule

// File: rtl/pattern_ctrl.sv
// Frame-synchronous pattern configuration controller.
// Host requests are computed, then applied only at a frame boundary.
module pattern_ctrl
  import pattern_pkg::*;
#(
  parameter int B               = 8,
  parameter int X_BITS          = 13,
  parameter int FRACTIONAL_BITS = 12
) (
  input  logic                          clk_in,
  input  logic                          reset,
  input  logic                          vn_in,
  input  logic [X_BITS-1:0]             total_active_pix,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [7:0]                    cfg_pattern,
  input  logic                          cfg_auto,
  input  logic [7:0]                    cfg_dwell,
  output logic [7:0]                    pattern,
  output logic [B+FRACTIONAL_BITS-1:0]  ramp_step,
  output logic                          frame_start,
  output logic                          applied,
  output logic                          div_err
);

  localparam int SW = B + FRACTIONAL_BITS;

  state_e        state_q, state_d;
  logic          vn_q;
  logic          fs_q;
  logic          ready_q, ready_d;
  logic [7:0]    pat_q, pat_d;
  logic [SW-1:0] step_q, step_d;
  logic          app_q, app_d;
  logic          err_q, err_d;
  logic          auto_q, auto_d;
  logic [7:0]    dwell_q, dwell_d;
  logic [7:0]    fcnt_q, fcnt_d;
  logic [7:0]    p_pat_q, p_pat_d;
  logic          p_auto_q, p_auto_d;
  logic [7:0]    p_dwell_q, p_dwell_d;

  logic          boundary;
  logic          accept;
  logic [7:0]    dwell_lim;
  logic          dv_done;
  logic [SW-1:0] dv_step;
  logic          dv_err;

  assign boundary  = vn_in & ~vn_q;
  assign accept    = cfg_valid & ready_q;
  assign dwell_lim = (dwell_q == 8'd0) ? 8'd0 : dwell_q - 8'd1;

  ramp_step_div #(
    .B               (B),
    .X_BITS          (X_BITS),
    .FRACTIONAL_BITS (FRACTIONAL_BITS)
  ) u_div (
    .clk_in  (clk_in),
    .reset   (reset),
    .start   (accept),
    .divisor (total_active_pix),
    .done    (dv_done),
    .step    (dv_step),
    .err     (dv_err)
  );

  // Request FSM, frame-boundary apply and auto-cycle stepping.
  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    pat_d     = pat_q;
    step_d    = step_q;
    app_d     = 1'b0;
    err_d     = err_q;
    auto_d    = auto_q;
    dwell_d   = dwell_q;
    fcnt_d    = fcnt_q;
    p_pat_d   = p_pat_q;
    p_auto_d  = p_auto_q;
    p_dwell_d = p_dwell_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          p_pat_d   = cfg_pattern;
          p_auto_d  = cfg_auto;
          p_dwell_d = cfg_dwell;
          ready_d   = 1'b0;
          state_d   = ST_CALC;
          if (total_active_pix != '0) begin
            err_d = 1'b0;
          end
        end else if (boundary && auto_q) begin
          if (fcnt_q >= dwell_lim) begin
            fcnt_d = 8'd0;
            pat_d  = next_auto(pat_q);
          end else begin
            fcnt_d = fcnt_q + 8'd1;
          end
        end
      end
      ST_CALC: begin
        if (dv_done) begin
          err_d   = dv_err;
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (boundary) begin
          pat_d   = p_pat_q;
          step_d  = dv_step;
          app_d   = 1'b1;
          auto_d  = p_auto_q;
          dwell_d = p_dwell_q;
          fcnt_d  = 8'd0;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // Controller state and output registers.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      vn_q      <= 1'b0;
      fs_q      <= 1'b0;
      ready_q   <= 1'b1;
      pat_q     <= PAT_NONE;
      step_q    <= '0;
      app_q     <= 1'b0;
      err_q     <= 1'b0;
      auto_q    <= 1'b0;
      dwell_q   <= 8'd0;
      fcnt_q    <= 8'd0;
      p_pat_q   <= 8'd0;
      p_auto_q  <= 1'b0;
      p_dwell_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      vn_q      <= vn_in;
      fs_q      <= boundary;
      ready_q   <= ready_d;
      pat_q     <= pat_d;
      step_q    <= step_d;
      app_q     <= app_d;
      err_q     <= err_d;
      auto_q    <= auto_d;
      dwell_q   <= dwell_d;
      fcnt_q    <= fcnt_d;
      p_pat_q   <= p_pat_d;
      p_auto_q  <= p_auto_d;
      p_dwell_q <= p_dwell_d;
    end
  end

  assign cfg_ready   = ready_q;
  assign pattern     = pat_q;
  assign ramp_step   = step_q;
  assign frame_start = fs_q;
  assign applied     = app_q;
  assign div_err     = err_q;

endmodule

// File: tb/tb_pattern_ctrl.sv
// Self-checking bench for pattern_ctrl.
// Table vectors, hand corner sequences and a random frame-level model.
module tb_pattern_ctrl;

  localparam int B  = 8;
  localparam int XB = 13;
  localparam int FB = 12;
  localparam int SW = B + FB;

  logic          clk_in;
  logic          reset;
  logic          vn_in;
  logic [XB-1:0] total_active_pix;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [7:0]    cfg_pattern;
  logic          cfg_auto;
  logic [7:0]    cfg_dwell;
  logic [7:0]    pattern;
  logic [SW-1:0] ramp_step;
  logic          frame_start;
  logic          applied;
  logic          div_err;

  pattern_ctrl #(.B(B), .X_BITS(XB), .FRACTIONAL_BITS(FB)) dut (
    .clk_in           (clk_in),
    .reset            (reset),
    .vn_in            (vn_in),
    .total_active_pix (total_active_pix),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_pattern      (cfg_pattern),
    .cfg_auto         (cfg_auto),
    .cfg_dwell        (cfg_dwell),
    .pattern          (pattern),
    .ramp_step        (ramp_step),
    .frame_start      (frame_start),
    .applied          (applied),
    .div_err          (div_err)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: run did not finish, required finish");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!cfg_ready && k < 200) begin
      tick();
      k++;
    end
    if (!cfg_ready) chk("ready_timeout", {31'd0, cfg_ready}, 1);
  endtask

  task automatic request(input int tap, input int pat,
                         input bit aut, input int dw);
    wait_ready();
    total_active_pix = XB'(tap);
    cfg_pattern      = 8'(pat);
    cfg_auto         = aut;
    cfg_dwell        = 8'(dw);
    cfg_valid        = 1'b1;
    tick();
    cfg_valid        = 1'b0;
  endtask

  function automatic int step_of(input int tap);
    longint q;
    if (tap == 0) return 0;
    q = (longint'(1) << SW) / tap;
    if (q > (longint'(1) << SW) - 1) q = (longint'(1) << SW) - 1;
    return int'(q);
  endfunction

  typedef struct {
    int tap;
    int pat;
    int exp_step;
    bit exp_err;
  } vec_t;

  vec_t tbl[7];

  int m_pat, m_step, m_cnt, m_dwell;
  bit m_auto;
  int exp_app;
  int lowc;
  int napp;
  int auto_exp[8];

  initial begin
    reset            = 1'b0;
    vn_in            = 1'b0;
    total_active_pix = '0;
    cfg_valid        = 1'b0;
    cfg_pattern      = 8'd0;
    cfg_auto         = 1'b0;
    cfg_dwell        = 8'd0;

    tbl[0] = '{1280, 4, 'h00333, 1'b0};
    tbl[1] = '{1920, 2, 'h00222, 1'b0};
    tbl[2] = '{0,    3, 0,       1'b1};
    tbl[3] = '{1,    1, 'hFFFFF, 1'b0};
    tbl[4] = '{1000, 4, 1048,    1'b0};
    tbl[5] = '{8191, 2, 128,     1'b0};
    tbl[6] = '{2,    0, 'h80000, 1'b0};

    #12;
    chk("rst_pattern", {24'd0, pattern}, 0);
    chk("rst_ramp", {12'd0, ramp_step}, 0);
    chk("rst_fs", {31'd0, frame_start}, 0);
    chk("rst_applied", {31'd0, applied}, 0);
    chk("rst_err", {31'd0, div_err}, 0);
    chk("rst_ready", {31'd0, cfg_ready}, 1);
    reset = 1'b1;
    tick();

    // Table vectors: request, busy window, apply at the next vn rise.
    for (int v = 0; v < 7; v++) begin
      request(tbl[v].tap, tbl[v].pat, 1'b0, 0);
      lowc = 0;
      for (int i = 0; i < 22; i++) begin
        if (!cfg_ready) lowc++;
        tick();
      end
      chk("busy_cycles", lowc, 22);
      vn_in = 1'b1;
      tick();
      chk("tbl_pattern", {24'd0, pattern}, tbl[v].pat);
      chk("tbl_ramp", {12'd0, ramp_step}, tbl[v].exp_step);
      chk("tbl_applied", {31'd0, applied}, 1);
      chk("tbl_fs", {31'd0, frame_start}, 1);
      chk("tbl_err", {31'd0, div_err}, tbl[v].exp_err);
      chk("tbl_ready", {31'd0, cfg_ready}, 1);
      tick();
      chk("tbl_applied_once", {31'd0, applied}, 0);
      vn_in = 1'b0;
      ticks(3);
    end

    // Boundary in the last divider cycle is ignored; the next one applies.
    request(1920, 3, 1'b0, 0);
    ticks(21);
    vn_in = 1'b1;
    tick();
    chk("calc_fs", {31'd0, frame_start}, 1);
    chk("calc_no_apply", {31'd0, applied}, 0);
    chk("calc_pattern_hold", {24'd0, pattern}, 0);
    vn_in = 1'b0;
    tick();
    vn_in = 1'b1;
    tick();
    chk("arm_applied", {31'd0, applied}, 1);
    chk("arm_pattern", {24'd0, pattern}, 3);
    chk("arm_ramp", {12'd0, ramp_step}, 546);
    vn_in = 1'b0;
    ticks(2);

    // Auto-cycle from pattern 3 with dwell 2 over eight frames.
    auto_exp = '{3, 3, 4, 4, 1, 1, 2, 2};
    request(1280, 3, 1'b1, 2);
    ticks(22);
    napp = 0;
    for (int f = 0; f < 8; f++) begin
      vn_in = 1'b1;
      tick();
      if (applied) napp++;
      chk("auto_pattern", {24'd0, pattern}, auto_exp[f]);
      chk("auto_fs", {31'd0, frame_start}, 1);
      tick();
      if (applied) napp++;
      vn_in = 1'b0;
      ticks(2);
    end
    chk("auto_applied_count", napp, 1);

    // Accept and boundary together: accept wins, no auto advance.
    total_active_pix = XB'(1280);
    cfg_pattern      = 8'd1;
    cfg_auto         = 1'b0;
    cfg_dwell        = 8'd0;
    cfg_valid        = 1'b1;
    vn_in            = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("same_fs", {31'd0, frame_start}, 1);
    chk("same_ready", {31'd0, cfg_ready}, 0);
    chk("same_no_advance", {24'd0, pattern}, 2);
    vn_in = 1'b0;
    ticks(22);
    vn_in = 1'b1;
    tick();
    chk("same_apply_pattern", {24'd0, pattern}, 1);
    chk("same_apply", {31'd0, applied}, 1);
    vn_in = 1'b0;
    ticks(3);
    vn_in = 1'b1;
    tick();
    chk("auto_off_hold", {24'd0, pattern}, 1);
    vn_in = 1'b0;
    ticks(3);

    // Reset during the divider run discards the pending request.
    request(1920, 4, 1'b1, 1);
    ticks(10);
    reset = 1'b0;
    #2;
    chk("mid_rst_pattern", {24'd0, pattern}, 0);
    chk("mid_rst_ramp", {12'd0, ramp_step}, 0);
    chk("mid_rst_ready", {31'd0, cfg_ready}, 1);
    chk("mid_rst_applied", {31'd0, applied}, 0);
    chk("mid_rst_err", {31'd0, div_err}, 0);
    #10;
    reset = 1'b1;
    tick();
    for (int f = 0; f < 3; f++) begin
      ticks(8);
      vn_in = 1'b1;
      tick();
      chk("post_rst_pattern", {24'd0, pattern}, 0);
      chk("post_rst_applied", {31'd0, applied}, 0);
      vn_in = 1'b0;
      ticks(2);
    end

    // Random requests and idle frames against a frame-level model.
    m_pat   = 0;
    m_step  = 0;
    m_auto  = 1'b0;
    m_dwell = 0;
    m_cnt   = 0;
    for (int it = 0; it < 40; it++) begin
      int op, tap, pat, dw, r;
      bit aut;
      op = $urandom_range(0, 2);
      if (op == 0) begin
        r = $urandom_range(0, 9);
        if (r == 0) tap = 0;
        else if (r == 1) tap = 1;
        else tap = $urandom_range(2, 8191);
        pat = $urandom_range(0, 7);
        aut = 1'($urandom_range(0, 1));
        dw  = $urandom_range(0, 3);
        request(tap, pat, aut, dw);
        ticks(22 + $urandom_range(0, 4));
        m_pat   = pat;
        m_step  = step_of(tap);
        m_auto  = aut;
        m_dwell = dw;
        m_cnt   = 0;
        exp_app = 1;
      end else begin
        if (m_auto) begin
          m_cnt++;
          if (m_cnt >= ((m_dwell == 0) ? 1 : m_dwell)) begin
            m_cnt = 0;
            m_pat = (m_pat >= 1 && m_pat <= 3) ? m_pat + 1 : 1;
          end
        end
        exp_app = 0;
      end
      vn_in = 1'b1;
      tick();
      chk("rnd_pattern", {24'd0, pattern}, m_pat);
      chk("rnd_ramp", {12'd0, ramp_step}, m_step);
      chk("rnd_applied", {31'd0, applied}, exp_app);
      chk("rnd_fs", {31'd0, frame_start}, 1);
      ticks($urandom_range(0, 2));
      vn_in = 1'b0;
      ticks($urandom_range(1, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
